// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, frame-error and done strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an o_parity_err strobe.
module uart_rx #(
  parameter int CLOCK_PER_BIT = 40
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_RX_bit,
  output logic [7:0] o_RX_byte,
  output logic       o_RX_done,
  output logic       o_receive_state,
  output logic       o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int CW = $clog2(CLOCK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCK_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, CLEANUP = 3'd4, PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, CLEANUP = 3'd4
  } state_t;
`endif

  state_t          state, state_n;
  logic            rx_meta, r_rx;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      byte_n;
  logic            done_n, ferr_n, recv_n;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_n, perr_n;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta         <= 1'b1;
      r_rx            <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      shreg           <= '0;
      o_RX_byte       <= '0;
      o_RX_done       <= 1'b0;
      o_frame_err     <= 1'b0;
      o_receive_state <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q           <= 1'b0;
      o_parity_err    <= 1'b0;
`endif
    end else begin
      rx_meta         <= i_RX_bit;
      r_rx            <= rx_meta;
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      shreg           <= shreg_n;
      o_RX_byte       <= byte_n;
      o_RX_done       <= done_n;
      o_frame_err     <= ferr_n;
      o_receive_state <= recv_n;
`ifdef UART_RX_PARITY_EN
      par_q           <= par_n;
      o_parity_err    <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    byte_n  = o_RX_byte;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    recv_n  = o_receive_state;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!r_rx) begin
          state_n = START;
          recv_n  = 1'b1;
        end
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!r_rx) begin
            state_n = DATA;
          end else begin
            state_n = IDLE;
            recv_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shreg_n[idx] = r_rx;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          par_n   = r_rx;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = CLEANUP;
          if (r_rx) begin
`ifdef UART_RX_PARITY_EN
            if (^{shreg, par_q}) begin
              perr_n = 1'b1;
            end else begin
              byte_n = shreg;
              done_n = 1'b1;
            end
`else
            byte_n = shreg;
            done_n = 1'b1;
`endif
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CLEANUP: begin
        // A stuck-low (break) line must not look like a new start bit.
        if (r_rx) begin
          state_n = IDLE;
          recv_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        recv_n  = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

endmodule
